// File: rtl/axis_downsizer_pkg.sv
// axis_downsizer_pkg: shared stream config type, downsizer FSM states and null-lane search helper
package axis_downsizer_pkg;
  localparam int MAXK = 64;
  typedef struct packed {
    int N;
    int I;
    int D;
    int U;
  } axis_cfg_t;
  typedef enum logic {EMPTY, LOADED} state_t;
  // Lowest sub-beat index >= start whose b keep bits are not all zero; r when none remain.
  function automatic int next_sub(input logic [MAXK-1:0] keep, input int start, input int r, input int b);
    logic [MAXK-1:0] mask;
    mask = (MAXK'(1) << b) - MAXK'(1);
    next_sub = r;
    for (int j = r - 1; j >= 0; j--)
      next_sub = (j >= start && ((keep >> (j * b)) & mask) != '0) ? j : next_sub;
  endfunction
endpackage

// File: rtl/axis_downsizer.sv
// axis_downsizer: splits each N-byte AXI-Stream beat into R narrower sub-beats, lane 0 first
//   aclk/aresetn                 clock, async active-low reset
//   s_t{valid,ready,last,data,keep,id,dest,user}  wide input stream
//   m_t{valid,ready,last,data,keep,id,dest,user}  N/R-byte output stream
//   AXIS_DOWNSIZER_SKIP_NULL_EN  when defined, sub-beats with all-zero keep are not emitted
module axis_downsizer
  import axis_downsizer_pkg::*;
#(
  parameter int N = 4,
  parameter int R = 4,
  parameter int I = 1,
  parameter int D = 1,
  parameter int U = 1,
  localparam axis_cfg_t CFG = '{N, I, D, U}
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  input  logic                     s_tlast,
  input  logic [8*CFG.N-1:0]       s_tdata,
  input  logic [CFG.N-1:0]         s_tkeep,
  input  logic [CFG.I-1:0]         s_tid,
  input  logic [CFG.D-1:0]         s_tdest,
  input  logic [CFG.U-1:0]         s_tuser,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic                     m_tlast,
  output logic [8*(CFG.N/R)-1:0]   m_tdata,
  output logic [CFG.N/R-1:0]       m_tkeep,
  output logic [CFG.I-1:0]         m_tid,
  output logic [CFG.D-1:0]         m_tdest,
  output logic [CFG.U-1:0]         m_tuser
);
  localparam int OB = CFG.N / R;
  localparam int KW = $clog2(R);
  if (R < 2 || N % R != 0) begin : g_bad_ratio
    $error("axis_downsizer: R must be >= 2 and divide N");
  end
  state_t state;
  logic [KW-1:0] k;
  logic [8*CFG.N-1:0] data_q;
  logic [CFG.N-1:0] keep_q;
  logic last_q;
  logic [CFG.I-1:0] id_q;
  logic [CFG.D-1:0] dest_q;
  logic [CFG.U-1:0] user_q;
  logic [KW:0] first_k, next_k;
  logic fin, emit, take;
`ifdef AXIS_DOWNSIZER_SKIP_NULL_EN
  if (N > MAXK) begin : g_bad_width
    $error("axis_downsizer: N exceeds null-lane search width");
  end
  assign first_k = (KW+1)'(next_sub(MAXK'(s_tkeep), 0, R, OB));
  assign next_k  = (KW+1)'(next_sub(MAXK'(keep_q), int'(k) + 1, R, OB));
  // an all-null beat only produces output when it carries the packet end
  assign emit    = first_k != (KW+1)'(R) || s_tlast;
`else
  assign first_k = '0;
  assign next_k  = {1'b0, k} + 1'b1;
  assign emit    = 1'b1;
`endif
  assign fin      = next_k == (KW+1)'(R);
  assign m_tvalid = state == LOADED;
  // gated by aresetn so the input is held off for the whole reset window
  assign s_tready = aresetn && (state == EMPTY || (fin && m_tready));
  assign take     = s_tvalid && s_tready;
  assign m_tdata  = data_q[k*8*OB +: 8*OB];
  assign m_tkeep  = keep_q[k*OB +: OB];
  assign m_tlast  = m_tvalid && last_q && fin;
  assign m_tid    = id_q;
  assign m_tdest  = dest_q;
  assign m_tuser  = user_q;
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      state  <= EMPTY;
      k      <= '0;
      data_q <= '0;
      keep_q <= '0;
      last_q <= 1'b0;
      id_q   <= '0;
      dest_q <= '0;
      user_q <= '0;
    end else if (take) begin
      state  <= emit ? LOADED : EMPTY;
      k      <= first_k == (KW+1)'(R) ? '0 : first_k[KW-1:0];
      data_q <= s_tdata;
      keep_q <= s_tkeep;
      last_q <= s_tlast;
      id_q   <= s_tid;
      dest_q <= s_tdest;
      user_q <= s_tuser;
    end else if (m_tvalid && m_tready) begin
      state <= fin ? EMPTY : LOADED;
      k     <= fin ? '0 : next_k[KW-1:0];
    end
endmodule

// File: tb/tb_axis_downsizer.sv
// tb_axis_downsizer: directed stimulus with a queue model of expected sub-beats checked every cycle
module tb_axis_downsizer;
`ifdef AXIS_DOWNSIZER_SKIP_NULL_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  logic aclk = 1'b0, aresetn = 1'b1;
  logic s_tvalid = 1'b0, s_tready, s_tlast = 1'b0;
  logic [31:0] s_tdata = '0;
  logic [3:0] s_tkeep = '0;
  logic s_tid = 1'b0, s_tdest = 1'b0, s_tuser = 1'b0;
  logic m_tvalid, m_tready = 1'b1, m_tlast;
  logic [7:0] m_tdata;
  logic m_tkeep, m_tid, m_tdest, m_tuser;
  typedef struct packed {
    logic [7:0] d;
    logic k;
    logic l;
    logic id;
    logic de;
    logic us;
  } beat_t;
  beat_t q[$];
  logic [7:0] log_d[$];
  logic log_k[$], log_l[$];
  int log_c[$];
  int chk = 0, pass = 0, cyc = 0;
  bit tgl = 1'b0;

  axis_downsizer #(.N(4), .R(4), .I(1), .D(1), .U(1)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
    .s_tid(s_tid), .s_tdest(s_tdest), .s_tuser(s_tuser),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
    .m_tid(m_tid), .m_tdest(m_tdest), .m_tuser(m_tuser)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    cyc++;
    #2;
    if (tgl) m_tready = ~m_tready;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Expected sub-beats of one accepted input beat, derived lane by lane.
  function automatic void push_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                                    input logic id, input logic de, input logic us);
    beat_t b[$];
    for (int j = 0; j < 4; j++)
      if (!SKIP || k[j]) b.push_back('{d[8*j +: 8], k[j], 1'b0, id, de, us});
    if (b.size() == 0 && l) b.push_back('{d[7:0], 1'b0, 1'b0, id, de, us});
    if (b.size() != 0) b[b.size()-1].l = l;
    foreach (b[i]) q.push_back(b[i]);
  endfunction

  always @(negedge aclk) begin
    if (!aresetn) begin
      q.delete();
      check("reset_outputs", {m_tvalid, m_tlast, m_tdata, m_tkeep, m_tid, m_tdest, m_tuser, s_tready}, 0);
    end else begin
      check("m_tvalid", m_tvalid, q.size() != 0);
      check("s_tready", s_tready, q.size() == 0 || (q.size() == 1 && m_tready));
      if (m_tvalid && q.size() != 0)
        check("beat", {m_tdata, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser}, q[0]);
      if (m_tvalid && m_tready) begin
        if (q.size() != 0) void'(q.pop_front());
        log_d.push_back(m_tdata);
        log_k.push_back(m_tkeep);
        log_l.push_back(m_tlast);
        log_c.push_back(cyc);
      end
      if (s_tvalid && s_tready) push_beat(s_tdata, s_tkeep, s_tlast, s_tid, s_tdest, s_tuser);
    end
  end

  task automatic clr();
    log_d.delete();
    log_k.delete();
    log_l.delete();
    log_c.delete();
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l,
                      input logic id, input logic de, input logic us);
    bit acc = 1'b0;
    s_tvalid = 1'b1;
    s_tdata = d;
    s_tkeep = k;
    s_tlast = l;
    s_tid = id;
    s_tdest = de;
    s_tuser = us;
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge aclk);
      acc = s_tready;
      @(posedge aclk);
      #2;
    end
    check("send_accepted", acc, 1);
  endtask

  task automatic drain();
    s_tvalid = 1'b0;
    for (int n = 0; n < 200 && q.size() != 0; n++) @(negedge aclk);
    check("drain_empty", q.size(), 0);
    @(posedge aclk);
    #2;
  endtask

  initial begin
    #1 aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #2;
    check("rst_s_tready", s_tready, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    aresetn = 1'b1;
    #1;
    check("release_s_tready", s_tready, 1);
    @(posedge aclk);
    #2;
    clr();
    send(32'h44332211, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1);
    drain();
    check("split_count", log_d.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("split_data", log_d[i], 8'h11 * (i + 1));
      check("split_last", log_l[i], i == 3);
    end
    check("split_span", log_c[3] - log_c[0], 3);
    clr();
    send(32'h88776655, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0);
    send(32'hCCBBAA99, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1);
    drain();
    check("b2b_count", log_d.size(), 8);
    check("b2b_span", log_c[7] - log_c[0], 7);
    check("b2b_data4", log_d[4], 8'h99);
    check("b2b_last3", log_l[3], 0);
    check("b2b_last7", log_l[7], 1);
    clr();
    m_tready = 1'b1;
    tgl = 1'b1;
    send(32'h04030201, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
    drain();
    tgl = 1'b0;
    m_tready = 1'b1;
    check("toggle_count", log_d.size(), 4);
    for (int i = 0; i < 4; i++) check("toggle_data", log_d[i], i + 1);
    for (int i = 1; i < 4; i++) check("toggle_gap", log_c[i] - log_c[i-1], 2);
    clr();
    send(32'hDD00BB00, 4'hA, 1'b1, 1'b0, 1'b0, 1'b0);
    drain();
`ifdef AXIS_DOWNSIZER_SKIP_NULL_EN
    check("sparse_count", log_d.size(), 2);
    check("sparse_d0", log_d[0], 8'hBB);
    check("sparse_d1", log_d[1], 8'hDD);
    check("sparse_l0", log_l[0], 0);
    check("sparse_l1", log_l[1], 1);
`else
    check("sparse_count", log_d.size(), 4);
    check("sparse_data", {log_d[0], log_d[1], log_d[2], log_d[3]}, 32'h00BB00DD);
    check("sparse_keep", {log_k[0], log_k[1], log_k[2], log_k[3]}, 4'b0101);
    check("sparse_last", {log_l[0], log_l[1], log_l[2], log_l[3]}, 4'b0001);
`endif
    clr();
    send(32'h00000000, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    drain();
`ifdef AXIS_DOWNSIZER_SKIP_NULL_EN
    check("null_last_count", log_d.size(), 1);
    check("null_last_keep", log_k[0], 0);
    check("null_last_last", log_l[0], 1);
`else
    check("null_last_count", log_d.size(), 4);
    check("null_last_keep", {log_k[0], log_k[1], log_k[2], log_k[3]}, 4'b0000);
    check("null_last_last", {log_l[0], log_l[1], log_l[2], log_l[3]}, 4'b0001);
`endif
    clr();
    send(32'h00000000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    check("null_mid_count", log_d.size(), SKIP ? 0 : 4);
    clr();
    m_tready = 1'b0;
    send(32'h5A6B7C8D, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (3) @(posedge aclk);
    #2;
    m_tready = 1'b1;
    drain();
    check("stall_count", log_d.size(), 4);
    check("stall_data", {log_d[0], log_d[1], log_d[2], log_d[3]}, 32'h8D7C6B5A);
    clr();
    send(32'h44332211, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
    s_tvalid = 1'b0;
    for (int n = 0; n < 50 && log_d.size() < 2; n++) @(negedge aclk);
    @(posedge aclk);
    #2;
    aresetn = 1'b0;
    #1;
    check("midrst_m_tvalid", m_tvalid, 0);
    check("midrst_m_tdata", m_tdata, 0);
    check("midrst_s_tready", s_tready, 0);
    repeat (2) @(posedge aclk);
    #2;
    aresetn = 1'b1;
    #1;
    check("midrst_release_s_tready", s_tready, 1);
    @(posedge aclk);
    #2;
    clr();
    send(32'h0D0C0B0A, 4'hF, 1'b1, 1'b0, 1'b1, 1'b1);
    drain();
    check("post_rst_count", log_d.size(), 4);
    check("post_rst_first", log_d[0], 8'h0A);
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d checks passed", pass, chk);
    $fatal(1);
  end
endmodule
